// File: rtl/act_pkg.sv
// Shared types for the streaming activation unit: activation mode encoding.
package act_pkg;

   typedef enum logic [1:0] {
      ACT_BYPASS = 2'd0,
      ACT_RELU   = 2'd1,
      ACT_LEAKY  = 2'd2,
      ACT_CLIP   = 2'd3
   } act_mode_t;

endpackage

// File: rtl/act_relu_stream_if.sv
// Handshake bundle for act_relu_stream: input beat stream plus output beat stream.
interface act_relu_stream_if
   import act_pkg::*;
#(
   parameter int D_WIDTH = 16,
   parameter int LANES   = 4
);
   logic                       in_valid;
   logic                       in_ready;
   logic [LANES*D_WIDTH-1:0]   in_data;
   act_mode_t                  in_mode;
   logic [D_WIDTH-2:0]         cfg_clip;
   logic                       out_valid;
   logic                       out_ready;
   logic [LANES*D_WIDTH-1:0]   out_data;

   // master: the surrounding datapath (producer upstream, consumer downstream)
   modport master (
      output in_valid, in_data, in_mode, cfg_clip, out_ready,
      input  in_ready, out_valid, out_data
   );

   // slave: the activation unit itself
   modport slave (
      input  in_valid, in_data, in_mode, cfg_clip, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/act_lane.sv
// Combinational single-lane activation: bypass, ReLU, leaky ReLU (arithmetic shift), clipped ReLU.
module act_lane
   import act_pkg::*;
#(
   parameter int D_WIDTH    = 16,
   parameter int LEAK_SHIFT = 3
) (
   input  logic signed [D_WIDTH-1:0] x,
   input  act_mode_t                 mode,
   input  logic        [D_WIDTH-2:0] clip,
   output logic signed [D_WIDTH-1:0] y
);
   logic signed [D_WIDTH-1:0] clip_ext;
   logic                      x_neg;

   // Ceiling is unsigned, so zero-extending keeps it non-negative as a signed word.
   assign clip_ext = $signed({1'b0, clip});
   assign x_neg    = x[D_WIDTH-1];

   always_comb begin
      y = x;
      case (mode)
         ACT_BYPASS: y = x;
         ACT_RELU:   y = x_neg ? '0 : x;
         ACT_LEAKY:  y = x_neg ? (x >>> LEAK_SHIFT) : x;
         ACT_CLIP:   y = x_neg ? '0 : ((x > clip_ext) ? clip_ext : x);
         default:    y = x;
      endcase
   end
endmodule

// File: rtl/act_relu_stream.sv
// Two-stage valid/ready activation pipeline over LANES words; ACT_ZCNT_EN adds a zero-result counter.
module act_relu_stream
   import act_pkg::*;
#(
   parameter int D_WIDTH    = 16,
   parameter int LANES      = 4,
   parameter int LEAK_SHIFT = 3
) (
   input  logic                clk,
   input  logic                rst,
`ifdef ACT_ZCNT_EN
   input  logic                zero_cnt_clr,
   output logic [31:0]         zero_cnt,
`endif
   act_relu_stream_if.slave    bus
);
   localparam int W = LANES * D_WIDTH;

   logic               s1_valid_q, s1_valid_d;
   logic [W-1:0]       s1_data_q,  s1_data_d;
   act_mode_t          s1_mode_q,  s1_mode_d;
   logic [D_WIDTH-2:0] s1_clip_q,  s1_clip_d;
   logic               s2_valid_q, s2_valid_d;
   logic [W-1:0]       s2_data_q,  s2_data_d;

   logic               s1_rdy;
   logic               s2_rdy;
   logic [W-1:0]       lane_y;

   assign s2_rdy       = !s2_valid_q || bus.out_ready;
   assign s1_rdy       = !s1_valid_q || s2_rdy;
   assign bus.in_ready = s1_rdy;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_data  = s2_data_q;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      act_lane #(
         .D_WIDTH    (D_WIDTH),
         .LEAK_SHIFT (LEAK_SHIFT)
      ) u_lane (
         .x    (s1_data_q[gi*D_WIDTH +: D_WIDTH]),
         .mode (s1_mode_q),
         .clip (s1_clip_q),
         .y    (lane_y[gi*D_WIDTH +: D_WIDTH])
      );
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_mode_d  = s1_mode_q;
      s1_clip_d  = s1_clip_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;

      // Mode and clip travel with their beat, so later changes cannot reach it.
      if (s1_rdy) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_data_d = bus.in_data;
            s1_mode_d = bus.in_mode;
            s1_clip_d = bus.cfg_clip;
         end
      end

      if (s2_rdy) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d = lane_y;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_mode_q  <= ACT_BYPASS;
         s1_clip_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_mode_q  <= s1_mode_d;
         s1_clip_q  <= s1_clip_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
      end
   end

`ifdef ACT_ZCNT_EN
   localparam int ZW = $clog2(LANES + 1);

   logic [LANES-1:0] lane_zero;
   logic [ZW-1:0]    zero_lanes;
   logic [32:0]      zero_sum;
   logic             out_xfer;
   logic [31:0]      zero_cnt_q, zero_cnt_d;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_zero
      assign lane_zero[gi] = (s2_data_q[gi*D_WIDTH +: D_WIDTH] == '0);
   end

   assign out_xfer = s2_valid_q && bus.out_ready;
   assign zero_cnt = zero_cnt_q;

   always_comb begin
      zero_lanes = '0;
      for (int i = 0; i < LANES; i++) begin
         zero_lanes = zero_lanes + ZW'(lane_zero[i]);
      end
      zero_sum   = {1'b0, zero_cnt_q} + 33'(zero_lanes);
      zero_cnt_d = zero_cnt_q;
      // Clear beats a same-cycle increment; the carry bit signals saturation.
      if (zero_cnt_clr) begin
         zero_cnt_d = '0;
      end else if (out_xfer) begin
         zero_cnt_d = zero_sum[32] ? '1 : zero_sum[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         zero_cnt_q <= '0;
      end else begin
         zero_cnt_q <= zero_cnt_d;
      end
   end
`endif
endmodule
